// File: rtl/hint_packer_if.sv
// Hint-beat stream into the packer and byte-write port toward the signature buffer.
interface hint_packer_if #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 7
);
    logic              hint_valid;
    logic              hint_ready;
    logic [LANES-1:0]  hint;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output hint_valid, hint, input hint_ready, wr_en, wr_addr, wr_data);
    modport slave  (input hint_valid, hint, output hint_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/hint_packer.sv
// Packs ML-DSA hint bits into the h-field: index bytes at 0..OMEGA-1, cumulative
// count bytes at OMEGA+poly; flags a signature with more than OMEGA hints.
module hint_packer #(
    parameter int OMEGA  = 75,
    parameter int K      = 8,
    parameter int N      = 256,
    parameter int LANES  = 4,
    parameter int ADDR_W = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          zeroize,
    input  logic          start,
    hint_packer_if.slave  bus,
    output logic          done,
    output logic          hint_invalid
);
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (K > 1) ? $clog2(K) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] OMEGA_A = ADDR_W'(OMEGA);
    localparam logic [ADDR_W-1:0] SAT_A   = ADDR_W'(OMEGA + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, PEND_CNT, DONE} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_poly_idx;
    logic [BW-1:0]     r_beat_cnt;
    logic [BW-1:0]     r_pend_beat;
    logic              r_all_acc;
    logic [LANES-1:0]  r_pend;
    logic [ADDR_W-1:0] r_total;
    logic              r_invalid;

    logic [LW-1:0]     w_lane;
    logic [LANES-1:0]  w_pend_clr;
    logic              w_multi;
    logic              w_drain;
    logic              w_idx_wr;
    logic              w_accept;
    logic [7:0]        w_coef;
    logic [7:0]        w_cnt;

    always_comb begin
        w_lane = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (r_pend[i]) w_lane = LW'(i);
    end

    // x & (x-1) drops the lowest set bit; nonzero result means two or more were set
    assign w_pend_clr = r_pend & (r_pend - LANES'(1));
    assign w_multi    = (w_pend_clr != '0);
    assign w_drain    = (r_state == ACCUM) && (r_pend != '0);
    assign w_idx_wr   = w_drain && (r_total < OMEGA_A);

    assign bus.hint_ready = (r_state == ACCUM) && !w_multi && !r_all_acc;
    assign w_accept       = bus.hint_valid && bus.hint_ready;

    assign w_coef = 8'(r_pend_beat) * 8'(LANES) + 8'(w_lane);
    assign w_cnt  = (r_total > OMEGA_A) ? 8'(OMEGA_A) : 8'(r_total);

    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        if (w_idx_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = r_total;
            bus.wr_data = w_coef;
        end else if (r_state == PEND_CNT) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = OMEGA_A + ADDR_W'(r_poly_idx);
            bus.wr_data = w_cnt;
        end
    end

    assign done         = (r_state == DONE);
    assign hint_invalid = r_invalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_poly_idx  <= '0;
            r_beat_cnt  <= '0;
            r_pend_beat <= '0;
            r_all_acc   <= 1'b0;
            r_pend      <= '0;
            r_total     <= '0;
            r_invalid   <= 1'b0;
        end else if (zeroize) begin
            r_state     <= IDLE;
            r_poly_idx  <= '0;
            r_beat_cnt  <= '0;
            r_pend_beat <= '0;
            r_all_acc   <= 1'b0;
            r_pend      <= '0;
            r_total     <= '0;
            r_invalid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ACCUM;
                        r_poly_idx <= '0;
                        r_beat_cnt <= '0;
                        r_all_acc  <= 1'b0;
                        r_pend     <= '0;
                        r_total    <= '0;
                        r_invalid  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (w_drain) begin
                        r_pend <= w_pend_clr;
                        if (r_total != SAT_A) r_total <= r_total + ADDR_W'(1);
                        if (r_total >= OMEGA_A) r_invalid <= 1'b1;
                    end
                    // accept only happens with <=1 pending bit, so the new beat replaces an empty pend
                    if (w_accept) begin
                        r_pend      <= bus.hint;
                        r_pend_beat <= r_beat_cnt;
                        r_beat_cnt  <= r_beat_cnt + BW'(1);
                        if (r_beat_cnt == BW'(BEATS - 1)) r_all_acc <= 1'b1;
                    end
                    if (r_all_acc && (r_pend == '0)) r_state <= PEND_CNT;
                end
                PEND_CNT: begin
                    r_poly_idx <= r_poly_idx + PW'(1);
                    r_beat_cnt <= '0;
                    r_all_acc  <= 1'b0;
                    r_state    <= (r_poly_idx == PW'(K - 1)) ? DONE : ACCUM;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hint_packer.sv
// Randomized bench: hint patterns are packed by a plain arithmetic model and the
// DUT's ordered write stream, done pulse, invalid flag and handshake count compared.
module tb_hint_packer;
    localparam int OMEGA  = 75;
    localparam int K      = 8;
    localparam int N      = 256;
    localparam int LANES  = 4;
    localparam int ADDR_W = 7;
    localparam int NB     = K * N / LANES;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic zeroize = 1'b0;
    logic start = 1'b0;
    logic done, hint_invalid;

    hint_packer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) ifc();

    hint_packer #(.OMEGA(OMEGA), .K(K), .N(N), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start),
        .bus(ifc.slave), .done(done), .hint_invalid(hint_invalid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] act_q[$];
    int done_cnt = 0;
    int hs_cnt = 0;

    always @(negedge clk) begin
        if (ifc.wr_en) act_q.push_back({1'b0, ifc.wr_addr, ifc.wr_data});
        if (done) done_cnt++;
        if (ifc.hint_valid && ifc.hint_ready) hs_cnt++;
    end

    logic hb [K*N];

    task automatic clear_hb();
        for (int i = 0; i < K * N; i++) hb[i] = 1'b0;
    endtask

    task automatic set_random_ones(input int cnt);
        int placed = 0;
        int idx;
        clear_hb();
        while (placed < cnt) begin
            idx = $urandom_range(K * N - 1);
            if (!hb[idx]) begin
                hb[idx] = 1'b1;
                placed++;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sig(input string nm, input int pct, input bit chk_gap);
        logic [15:0] exp_q[$];
        logic [LANES-1:0] b;
        int ones = 0;
        int base, d0, h0, beat, cyc, gap, n;
        bit fire, hv;
        for (int p = 0; p < K; p++) begin
            for (int c = 0; c < N; c++) begin
                if (hb[p*N + c]) begin
                    ones++;
                    if (ones <= OMEGA) exp_q.push_back({1'b0, ADDR_W'(ones - 1), 8'(c)});
                end
            end
            exp_q.push_back({1'b0, ADDR_W'(OMEGA + p), 8'((ones > OMEGA) ? OMEGA : ones)});
        end
        base = act_q.size();
        d0 = done_cnt;
        h0 = hs_cnt;
        do_start();
        beat = 0; cyc = 0; gap = 0;
        while (beat < NB && cyc < 20000) begin
            hv = ($urandom_range(99) < pct);
            for (int i = 0; i < LANES; i++) b[i] = hb[beat*LANES + i];
            ifc.hint_valid = hv;
            ifc.hint = hv ? b : LANES'($urandom);
            @(negedge clk);
            fire = hv && ifc.hint_ready;
            if (!ifc.hint_ready && beat == 1) gap++;
            @(posedge clk); #1;
            if (fire) beat++;
            cyc++;
        end
        ifc.hint_valid = 1'b0;
        check({nm, " beats"}, beat, NB);
        cyc = 0;
        while (done_cnt == d0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        check({nm, " done"}, done_cnt - d0, 1);
        check({nm, " handshakes"}, hs_cnt - h0, NB);
        check({nm, " invalid"}, hint_invalid, (ones > OMEGA) ? 1 : 0);
        if (chk_gap) check({nm, " ready_gap"}, gap, 2);
        check({nm, " nwr"}, act_q.size() - base, exp_q.size());
        n = (act_q.size() - base < exp_q.size()) ? act_q.size() - base : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s wr[%0d]", nm, i), act_q[base + i], exp_q[i]);
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, " wr_en"}, ifc.wr_en, 0);
        check({nm, " wr_addr"}, ifc.wr_addr, 0);
        check({nm, " wr_data"}, ifc.wr_data, 0);
        check({nm, " ready"}, ifc.hint_ready, 0);
        check({nm, " done"}, done, 0);
        check({nm, " invalid"}, hint_invalid, 0);
    endtask

    // drives all-ones beats long enough to overflow OMEGA inside poly 0
    task automatic overflow_prelude(input string nm);
        do_start();
        ifc.hint_valid = 1'b1;
        ifc.hint = '1;
        repeat (120) @(posedge clk);
        #1;
        check({nm, " pre_invalid"}, hint_invalid, 1);
    endtask

    initial begin
        int d0;
        ifc.hint_valid = 1'b0;
        ifc.hint = '0;
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        clear_hb();
        run_sig("s1 zero", 80, 1'b0);

        clear_hb();
        hb[0] = 1'b1; hb[1] = 1'b1; hb[3] = 1'b1;
        run_sig("s2 1011", 100, 1'b1);

        set_random_ones(OMEGA);
        run_sig("s3 omega", 70, 1'b0);

        set_random_ones(OMEGA + 1);
        run_sig("s4 omega+1", 60, 1'b0);

        clear_hb();
        for (int c = 0; c < N; c++) hb[3*N + c] = 1'b1;
        run_sig("s5 poly3", 50, 1'b0);

        set_random_ones(40 + $urandom_range(60));
        run_sig("rand", 75, 1'b0);

        overflow_prelude("zeroize");
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        @(negedge clk);
        check_idle_zero("zeroize");
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("zeroize no_done", done_cnt - d0, 0);
        ifc.hint_valid = 1'b0;
        @(posedge clk); #1;

        overflow_prelude("rstpulse");
        #3;
        reset_n = 1'b0;
        #1;
        check_idle_zero("rstpulse");
        @(posedge clk); #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("rstpulse no_done", done_cnt - d0, 0);
        ifc.hint_valid = 1'b0;
        @(posedge clk); #1;

        clear_hb();
        run_sig("s6 clean", 90, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
